// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder:
// glyph table, FSM state encoding, default settle length and AN helpers.
package seg_pkg;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_HELD   = 1'b1
   } scan_state_t;

   // Active-high {g,f,e,d,c,b,a} patterns, indexed by the nibble they show.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic is_one_hot(input logic [7:0] bits);
      return (bits != 8'h00) && ((bits & (bits - 8'h01)) == 8'h00);
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational lookup from an active-high segment pattern to its hex nibble.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [3:0] nibble,
   output logic       valid
);

   // Linear search of the glyph table; no match leaves valid low.
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (glyph == GLYPH_TABLE[i]) begin
            nibble = 4'(i);
            valid  = 1'b1;
         end else begin
            nibble = nibble;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 32-bit hex value by watching a scanned seven-segment display bus;
// each digit must be stable for STABLE_CYCLES samples before it is accepted.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  SEG,
   input  logic [7:0]  AN,
   input  logic        err_clr,
   output logic [31:0] value,
   output logic        frame_done,
   output logic [7:0]  digit_seen,
   output logic        err_code,
   output logic        err_an
);

   localparam logic [15:0] STABLE_TARGET = STABLE_CYCLES[15:0];

   logic [7:0]  seg_r, an_r, prev_seg_r, prev_an_r;
   logic [15:0] cnt_r;
   scan_state_t state_r;
   logic [31:0] shadow_r;

   logic [15:0] cnt_inc_s;
   logic [7:0]  an_low_s;
   logic [3:0]  nibble_s;
   logic        valid_s, same_s, commit_s, one_hot_s, blank_s;
   logic        digit_wr_s, code_err_s, an_err_s, frame_ready_s;

   seg_glyph_decode u_glyph (
      .glyph  (~seg_r[6:0]),
      .nibble (nibble_s),
      .valid  (valid_s)
   );

   // Stability tracking and classification of the committed sample.
   always_comb begin
      same_s        = ({an_r, seg_r} == {prev_an_r, prev_seg_r});
      cnt_inc_s     = cnt_r + 16'd1;
      commit_s      = (state_r == ST_SETTLE) && same_s && (cnt_inc_s == STABLE_TARGET);
      an_low_s      = ~an_r;
      one_hot_s     = is_one_hot(an_low_s);
      blank_s       = (an_r == 8'hFF);
      digit_wr_s    = commit_s && one_hot_s && valid_s;
      code_err_s    = commit_s && one_hot_s && !valid_s;
      an_err_s      = commit_s && !one_hot_s && !blank_s;
      frame_ready_s = (digit_seen == 8'hFF);
   end

   // Input stage, previous-sample register and SETTLE/HELD state machine.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         seg_r      <= 8'hFF;
         an_r       <= 8'hFF;
         prev_seg_r <= 8'hFF;
         prev_an_r  <= 8'hFF;
         cnt_r      <= 16'd0;
         state_r    <= ST_SETTLE;
      end else begin
         seg_r      <= SEG;
         an_r       <= AN;
         prev_seg_r <= seg_r;
         prev_an_r  <= an_r;
         if (!same_s) begin
            cnt_r   <= 16'd1;
            state_r <= ST_SETTLE;
         end else begin
            cnt_r   <= (cnt_r != 16'hFFFF) ? cnt_inc_s : cnt_r;
            state_r <= commit_s ? ST_HELD : state_r;
         end
      end
   end

   // Shadow frame assembly and hand-off of a complete frame to value.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         shadow_r   <= 32'h0000_0000;
         value      <= 32'h0000_0000;
         digit_seen <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_ready_s) begin
            value      <= shadow_r;
            frame_done <= 1'b1;
            digit_seen <= 8'h00;
         end else if (digit_wr_s) begin
            for (int i = 0; i < 8; i++) begin
               if (an_low_s[i]) begin
                  shadow_r[4*i +: 4] <= nibble_s;
               end
            end
            digit_seen <= digit_seen | an_low_s;
         end else begin
            digit_seen <= digit_seen;
         end
      end
   end

   // Sticky error flags; a same-cycle set wins over err_clr.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         err_code <= 1'b0;
         err_an   <= 1'b0;
      end else begin
         if (code_err_s) begin
            err_code <= 1'b1;
         end else if (err_clr) begin
            err_code <= 1'b0;
         end else begin
            err_code <= err_code;
         end
         if (an_err_s) begin
            err_an <= 1'b1;
         end else if (err_clr) begin
            err_an <= 1'b0;
         end else begin
            err_an <= err_an;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder with STABLE_CYCLES=4.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [7:0]  SEG = 8'hFF;
   logic [7:0]  AN  = 8'hFF;
   logic        err_clr = 1'b0;
   logic [31:0] value;
   logic        frame_done;
   logic [7:0]  digit_seen;
   logic        err_code, err_an;

   int n_vec = 0;
   int n_bad = 0;
   int fd_count = 0;

   logic [6:0] tb_glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .clr(clr), .SEG(SEG), .AN(AN), .err_clr(err_clr),
      .value(value), .frame_done(frame_done), .digit_seen(digit_seen),
      .err_code(err_code), .err_an(err_an)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_count++;
   end

   function automatic logic [7:0] seg_for(input logic [3:0] n);
      return {1'b1, ~tb_glyph[n]};
   endfunction

   task automatic present(input logic [7:0] an, input logic [7:0] seg, input int n);
      AN  = an;
      SEG = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_word(input logic [31:0] word);
      for (int i = 0; i < 8; i++) begin
         present(~(8'h01 << i), seg_for(word[4*i +: 4]), 6);
      end
      present(8'hFF, 8'hFF, 4);
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (value !== 32'h0) begin n_bad++; $display("FAIL reset_value got %h exp 00000000", value); end
      n_vec++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      n_vec++; if (digit_seen !== 8'h00) begin n_bad++; $display("FAIL reset_digit_seen got %h exp 00", digit_seen); end
      n_vec++; if ({err_code, err_an} !== 2'b00) begin n_bad++; $display("FAIL reset_errs got %b exp 00", {err_code, err_an}); end
      clr = 1'b0;
      present(8'hFF, 8'hFF, 6);
   endtask

   task automatic test_full_scan();
      fd_count = 0;
      scan_word(32'h1234_ABCD);
      n_vec++; if (value !== 32'h1234_ABCD) begin n_bad++; $display("FAIL scan_value got %h exp 1234abcd", value); end
      n_vec++; if (fd_count !== 1) begin n_bad++; $display("FAIL scan_frame_done_cycles got %0d exp 1", fd_count); end
      n_vec++; if (digit_seen !== 8'h00) begin n_bad++; $display("FAIL scan_digit_seen got %h exp 00", digit_seen); end
      n_vec++; if ({err_code, err_an} !== 2'b00) begin n_bad++; $display("FAIL scan_errs got %b exp 00", {err_code, err_an}); end
   endtask

   task automatic test_latency();
      AN  = 8'hFB;
      SEG = seg_for(4'h2);
      repeat (4) @(posedge clk);
      #1;
      n_vec++; if (digit_seen !== 8'h00) begin n_bad++; $display("FAIL latency_early got %h exp 00", digit_seen); end
      @(posedge clk);
      #1;
      n_vec++; if (digit_seen !== 8'h04) begin n_bad++; $display("FAIL latency_accept got %h exp 04", digit_seen); end
      present(8'hFB, seg_for(4'h2), 1);
      present(8'hFF, 8'hFF, 6);
   endtask

   task automatic test_short_hold();
      fd_count = 0;
      present(8'hDF, seg_for(4'h5), 3);
      present(8'hFF, 8'hFF, 8);
      n_vec++; if (digit_seen !== 8'h04) begin n_bad++; $display("FAIL short_hold_seen got %h exp 04", digit_seen); end
      n_vec++; if (value !== 32'h1234_ABCD) begin n_bad++; $display("FAIL short_hold_value got %h exp 1234abcd", value); end
      n_vec++; if (fd_count !== 0) begin n_bad++; $display("FAIL short_hold_frame got %0d exp 0", fd_count); end
   endtask

   task automatic test_code_err();
      present(8'hFE, 8'hFF, 6);
      n_vec++; if (err_code !== 1'b1) begin n_bad++; $display("FAIL code_err_set got %b exp 1", err_code); end
      n_vec++; if (digit_seen !== 8'h04) begin n_bad++; $display("FAIL code_err_seen got %h exp 04", digit_seen); end
      n_vec++; if (err_an !== 1'b0) begin n_bad++; $display("FAIL code_err_an got %b exp 0", err_an); end
      err_clr = 1'b1;
      present(8'hFE, 8'hFF, 1);
      err_clr = 1'b0;
      n_vec++; if (err_code !== 1'b0) begin n_bad++; $display("FAIL code_err_clear got %b exp 0", err_code); end
      present(8'hFF, 8'hFF, 6);
   endtask

   task automatic test_err_priority();
      err_clr = 1'b1;
      present(8'hFD, 8'hFE, 5);
      n_vec++; if (err_code !== 1'b1) begin n_bad++; $display("FAIL priority_set_wins got %b exp 1", err_code); end
      present(8'hFD, 8'hFE, 1);
      n_vec++; if (err_code !== 1'b0) begin n_bad++; $display("FAIL priority_then_clear got %b exp 0", err_code); end
      err_clr = 1'b0;
      present(8'hFF, 8'hFF, 6);
   endtask

   task automatic test_an_err();
      present(8'hFC, seg_for(4'h1), 6);
      n_vec++; if (err_an !== 1'b1) begin n_bad++; $display("FAIL an_err_set got %b exp 1", err_an); end
      n_vec++; if (digit_seen !== 8'h04) begin n_bad++; $display("FAIL an_err_seen got %h exp 04", digit_seen); end
      err_clr = 1'b1;
      present(8'hFC, seg_for(4'h1), 1);
      err_clr = 1'b0;
      present(8'hFF, 8'hFF, 6);
      n_vec++; if ({err_code, err_an} !== 2'b00) begin n_bad++; $display("FAIL blank_no_err got %b exp 00", {err_code, err_an}); end
      n_vec++; if (digit_seen !== 8'h04) begin n_bad++; $display("FAIL blank_seen got %h exp 04", digit_seen); end
   endtask

   task automatic test_rescan();
      fd_count = 0;
      present(8'hFE, seg_for(4'h0), 6);
      present(8'hFD, seg_for(4'h1), 6);
      present(8'hFB, seg_for(4'h2), 6);
      present(8'hF7, seg_for(4'h7), 6);
      present(8'hF7, seg_for(4'h9), 6);
      present(8'hEF, seg_for(4'h8), 6);
      present(8'hDF, seg_for(4'h7), 6);
      present(8'hBF, seg_for(4'h6), 6);
      present(8'h7F, seg_for(4'h5), 6);
      present(8'hFF, 8'hFF, 4);
      n_vec++; if (value !== 32'h5678_9210) begin n_bad++; $display("FAIL rescan_value got %h exp 56789210", value); end
      n_vec++; if (fd_count !== 1) begin n_bad++; $display("FAIL rescan_frame got %0d exp 1", fd_count); end
   endtask

   task automatic test_clr_midframe();
      for (int i = 0; i < 5; i++) begin
         present(~(8'h01 << i), seg_for(4'hC), 6);
      end
      n_vec++; if (digit_seen !== 8'h1F) begin n_bad++; $display("FAIL midframe_seen got %h exp 1f", digit_seen); end
      clr = 1'b1;
      #1;
      n_vec++; if (value !== 32'h0) begin n_bad++; $display("FAIL clr_value got %h exp 00000000", value); end
      n_vec++; if (digit_seen !== 8'h00) begin n_bad++; $display("FAIL clr_seen got %h exp 00", digit_seen); end
      n_vec++; if ({frame_done, err_code, err_an} !== 3'b000) begin n_bad++; $display("FAIL clr_flags got %b exp 000", {frame_done, err_code, err_an}); end
      AN  = 8'hFF;
      SEG = 8'hFF;
      @(posedge clk);
      #1;
      clr = 1'b0;
      present(8'hFF, 8'hFF, 3);
      fd_count = 0;
      scan_word(32'hDEAD_BEEF);
      n_vec++; if (value !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL deadbeef_value got %h exp deadbeef", value); end
      n_vec++; if (fd_count !== 1) begin n_bad++; $display("FAIL deadbeef_frame got %0d exp 1", fd_count); end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_latency();
      test_short_hold();
      test_code_err();
      test_err_priority();
      test_an_err();
      test_rescan();
      test_clr_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
